// File: rtl/te_wta.sv
// te_wta: temporal-encoding winner-take-all.
// Races CHANNELS temporally encoded lines inside a frame delimited by toggles
// of tin. Each channel's arrival cycle (counted from the first cycle after the
// frame boundary) is recorded once per frame. When the next boundary closes the
// frame, the earliest (MODE=0) or latest (MODE=1) arrival is reported with a
// one-cycle valid pulse. Ties resolve to the lowest index and raise tie.
// Optional build macro TE_WTA_TIMES_EN: when defined, the times port carries the
// latched per-channel arrival counts (2**BITS for channels that never arrived);
// otherwise times is tied to zero.
module te_wta #(
  parameter int BITS     = 3,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tin,
  input  logic [CHANNELS-1:0]            t_in,
  output logic                           valid,
  output logic [$clog2(CHANNELS)-1:0]    win_idx,
  output logic [BITS:0]                  win_time,
  output logic                           tie,
  output logic                           none,
  output logic [CHANNELS*(BITS+1)-1:0]   times
);

  localparam int IDXW = $clog2(CHANNELS);
  localparam int TW   = BITS + 1;
  localparam logic [BITS:0] SENT = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS:0] ONE  = {{BITS{1'b0}}, 1'b1};

  typedef enum logic {IDLE, RACE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_tin_q;
  logic                 w_boundary;
  logic                 w_clear;
  logic                 w_latch;
  logic                 w_record;

  logic [BITS:0]        r_cnt_p0;
  logic [CHANNELS-1:0]  r_seen_p0;
  logic [BITS:0]        r_rec_p0 [CHANNELS];
  logic [CHANNELS-1:0]  w_active;
  logic [CHANNELS-1:0]  w_arrive;

  logic [IDXW-1:0]      w_best_idx;
  logic [BITS:0]        w_best_time;
  logic                 w_any;
  logic                 w_tie;
  logic                 w_hit;

  logic                 r_vld_p1;
  logic [IDXW-1:0]      r_win_idx_p1;
  logic [BITS:0]        r_win_time_p1;
  logic                 r_tie_p1;
  logic                 r_none_p1;

  // Frame counter saturates at the sentinel so late arrivals stay ignorable.
  function automatic logic [BITS:0] sat_inc(input logic [BITS:0] v);
    return (v == SENT) ? v : v + ONE;
  endfunction

  // Ordering used to pick the winner: strict, so the lowest index keeps ties.
  function automatic logic better(input logic [BITS:0] a, input logic [BITS:0] b);
    return (MODE == 0) ? (a < b) : (a > b);
  endfunction

  assign w_boundary = (tin != r_tin_q);
  assign w_active   = t_in ^ {CHANNELS{r_tin_q}};
  assign w_arrive   = w_active & ~r_seen_p0 &
                      {CHANNELS{w_record && (r_cnt_p0 != SENT)}};

  // State register and delayed frame phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tin_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tin_q <= tin;
    end
  end

  // Next state and per-cycle control: first boundary only arms the race.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_latch     = 1'b0;
    w_record    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_boundary) begin
          w_state_nxt = RACE;
          w_clear     = 1'b1;
        end
      end
      RACE: begin
        if (w_boundary) begin
          w_latch = 1'b1;
          w_clear = 1'b1;
        end else begin
          w_record = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: per-frame arrival capture ----
  // Record the counter value for each first arrival; clear at every boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_p0  <= '0;
      r_seen_p0 <= '0;
      for (int i = 0; i < CHANNELS; i++) r_rec_p0[i] <= SENT;
    end else if (w_clear) begin
      r_cnt_p0  <= '0;
      r_seen_p0 <= '0;
      for (int i = 0; i < CHANNELS; i++) r_rec_p0[i] <= SENT;
    end else if (w_record) begin
      r_cnt_p0  <= sat_inc(r_cnt_p0);
      r_seen_p0 <= r_seen_p0 | w_arrive;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_arrive[i]) r_rec_p0[i] <= r_cnt_p0;
      end
    end
  end

  // Winner search over arrived channels, then tie detection on the best time.
  always_comb begin
    w_best_idx  = '0;
    w_best_time = SENT;
    w_any       = 1'b0;
    w_tie       = 1'b0;
    w_hit       = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_seen_p0[i]) begin
        if (!w_any || better(r_rec_p0[i], w_best_time)) begin
          w_best_idx  = IDXW'(i);
          w_best_time = r_rec_p0[i];
        end
        w_any = 1'b1;
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_seen_p0[i] && (r_rec_p0[i] == w_best_time)) begin
        if (w_hit) w_tie = 1'b1;
        w_hit = 1'b1;
      end
    end
  end

  // ---- stage p1: frame result, held until the next frame closes ----
  // Latch the closing frame's result and pulse valid for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_win_idx_p1  <= '0;
      r_win_time_p1 <= '0;
      r_tie_p1      <= 1'b0;
      r_none_p1     <= 1'b0;
    end else begin
      r_vld_p1 <= w_latch;
      if (w_latch) begin
        r_win_idx_p1  <= w_best_idx;
        r_win_time_p1 <= w_best_time;
        r_tie_p1      <= w_tie;
        r_none_p1     <= ~w_any;
      end
    end
  end

`ifdef TE_WTA_TIMES_EN
  logic [CHANNELS*TW-1:0] w_times_flat;
  logic [CHANNELS*TW-1:0] r_times_p1;

  // Pack recorded times, channel 0 in the least significant field.
  always_comb begin
    w_times_flat = '0;
    for (int i = 0; i < CHANNELS; i++) w_times_flat[i*TW +: TW] = r_rec_p0[i];
  end

  // Latch per-channel times alongside the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_times_p1 <= '0;
    else if (w_latch) r_times_p1 <= w_times_flat;
  end

  assign times = r_times_p1;
`else
  assign times = '0;
`endif

  assign valid    = r_vld_p1;
  assign win_idx  = r_win_idx_p1;
  assign win_time = r_win_time_p1;
  assign tie      = r_tie_p1;
  assign none     = r_none_p1;

endmodule

// File: tb/tb_te_wta.sv
// Bench for te_wta: two instances (earliest-wins and latest-wins) share one
// stimulus stream. Frames are described by per-channel arrival offsets; the
// expected result of each frame is derived from those offsets directly.
module tb_te_wta;
  localparam int B    = 3;
  localparam int CH   = 4;
  localparam int TW   = B + 1;
  localparam int IW   = 2;
  localparam int SENT = 8;

  logic clk = 1'b0;
  logic rst;
  logic tin;
  logic [CH-1:0] t_in;
  logic v0, v1, tie0, tie1, none0, none1;
  logic [IW-1:0] idx0, idx1;
  logic [B:0] wt0, wt1;
  logic [CH*TW-1:0] tm0, tm1;

  te_wta #(.BITS(B), .CHANNELS(CH), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .tin(tin), .t_in(t_in), .valid(v0), .win_idx(idx0),
    .win_time(wt0), .tie(tie0), .none(none0), .times(tm0));

  te_wta #(.BITS(B), .CHANNELS(CH), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .tin(tin), .t_in(t_in), .valid(v1), .win_idx(idx1),
    .win_time(wt1), .tie(tie1), .none(none1), .times(tm1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int arr [CH];
  bit glitch [CH];
  int pend_idx [2];
  int pend_time [2];
  int pend_tie [2];
  int pend_none;
  int pend_times [CH];
  int exp_idx [2];
  int exp_time [2];
  int exp_tie [2];
  int exp_none;
  int exp_times [CH];
  int exp_vld;
  bit have_prev;
  bit chk_en;

  task automatic chk(input string name, input logic [31:0] act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_tm(input int c);
`ifdef TE_WTA_TIMES_EN
    return exp_times[c];
`else
    return 0 * c;
`endif
  endfunction

  // Expected frame result: an offset counts if it is inside the count window
  // and lands before the closing boundary cycle (frame length L).
  task automatic model(input int L);
    int t [CH];
    int best;
    int cnt;
    pend_none = 1;
    for (int c = 0; c < CH; c++) begin
      t[c] = (arr[c] >= 0 && arr[c] <= L - 2 && arr[c] < SENT) ? arr[c] : SENT;
      if (t[c] != SENT) pend_none = 0;
      pend_times[c] = t[c];
    end
    for (int m = 0; m < 2; m++) begin
      best = -1;
      for (int c = 0; c < CH; c++)
        if (t[c] != SENT && (best < 0 || (m == 0 ? t[c] < t[best] : t[c] > t[best])))
          best = c;
      if (best < 0) begin
        pend_idx[m] = 0; pend_time[m] = SENT; pend_tie[m] = 0;
      end else begin
        cnt = 0;
        for (int c = 0; c < CH; c++) if (t[c] == t[best]) cnt++;
        pend_idx[m] = best; pend_time[m] = t[best]; pend_tie[m] = (cnt > 1) ? 1 : 0;
      end
    end
  endtask

  task automatic clear_exp();
    for (int m = 0; m < 2; m++) begin
      exp_idx[m] = 0; exp_time[m] = 0; exp_tie[m] = 0;
    end
    exp_none = 0;
    for (int c = 0; c < CH; c++) exp_times[c] = 0;
  endtask

  // Drive one frame of L cycles starting just after a rising edge. Cycle 0 is
  // the boundary cycle; arrival offset a is driven from cycle a+1.
  task automatic run_frame(input logic ph, input bit tog, input int L, input int rst_at);
    for (int j = 0; j < L; j++) begin
      if (j == 0) begin
        if (tog) tin = ph;
        t_in = {CH{ph}};
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (arr[c] >= 0 && j == arr[c] + 1) t_in[c] = ~ph;
          else if (glitch[c] && arr[c] >= 0 && j == arr[c] + 2) t_in[c] = ph;
        end
      end
      exp_vld = (j == 1 && have_prev) ? 1 : 0;
      if (exp_vld == 1) begin
        for (int m = 0; m < 2; m++) begin
          exp_idx[m] = pend_idx[m]; exp_time[m] = pend_time[m]; exp_tie[m] = pend_tie[m];
        end
        exp_none = pend_none;
        for (int c = 0; c < CH; c++) exp_times[c] = pend_times[c];
      end
      if (j == rst_at) begin
        rst = 1'b1;
        exp_vld = 0;
        have_prev = 1'b0;
        clear_exp();
        return;
      end
      @(posedge clk); #1;
    end
    model(L);
    have_prev = 1'b1;
  endtask

  // Single compare process: valid every cycle, held outputs every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_m0", 32'(v0), exp_vld);
      chk("valid_m1", 32'(v1), exp_vld);
      chk("win_idx_m0", 32'(idx0), exp_idx[0]);
      chk("win_idx_m1", 32'(idx1), exp_idx[1]);
      chk("win_time_m0", 32'(wt0), exp_time[0]);
      chk("win_time_m1", 32'(wt1), exp_time[1]);
      chk("tie_m0", 32'(tie0), exp_tie[0]);
      chk("tie_m1", 32'(tie1), exp_tie[1]);
      chk("none_m0", 32'(none0), exp_none);
      chk("none_m1", 32'(none1), exp_none);
      for (int c = 0; c < CH; c++) begin
        chk("times_m0", 32'(tm0[c*TW +: TW]), exp_tm(c));
        chk("times_m1", 32'(tm1[c*TW +: TW]), exp_tm(c));
      end
    end
  end

  initial begin
    logic ph;
    int L;
    rst = 1'b1; tin = 1'b1; t_in = '1;
    exp_vld = 0; have_prev = 1'b0; chk_en = 1'b0;
    for (int c = 0; c < CH; c++) glitch[c] = 1'b0;
    clear_exp();

    // Hand-computed pins on the model.
    arr = '{5, 2, 7, 3}; model(10);
    chk("pin_a_idx", 32'(pend_idx[0]), 1);
    chk("pin_a_time", 32'(pend_time[0]), 2);
    chk("pin_a_tie", 32'(pend_tie[0]), 0);
    chk("pin_a_none", 32'(pend_none), 0);
    arr = '{4, 4, 6, -1}; model(10);
    chk("pin_b_idx", 32'(pend_idx[0]), 0);
    chk("pin_b_time", 32'(pend_time[0]), 4);
    chk("pin_b_tie", 32'(pend_tie[0]), 1);
    chk("pin_b_t2", 32'(pend_times[2]), 6);
    chk("pin_b_t3", 32'(pend_times[3]), 8);
    arr = '{1, 6, 3, -1}; model(10);
    chk("pin_c_idx", 32'(pend_idx[1]), 1);
    chk("pin_c_time", 32'(pend_time[1]), 6);
    chk("pin_c_tie", 32'(pend_tie[1]), 0);
    arr = '{-1, -1, -1, -1}; model(10);
    chk("pin_d_none", 32'(pend_none), 1);
    chk("pin_d_time", 32'(pend_time[0]), 8);
    chk("pin_d_idx", 32'(pend_idx[0]), 0);
    arr = '{5, -1, 1, -1}; model(10);
    chk("pin_e_idx", 32'(pend_idx[0]), 2);
    chk("pin_e_time", 32'(pend_time[0]), 1);

    chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;   // tin=1 at release: immediate boundary, no valid

    arr = '{4, 4, 6, -1};  run_frame(1'b1, 1'b0, 10, -1);
    arr = '{5, 2, 7, 3};   run_frame(1'b0, 1'b1, 10, -1);
    arr = '{1, 6, 3, -1};  run_frame(1'b1, 1'b1, 10, -1);
    arr = '{-1, -1, -1, -1}; run_frame(1'b0, 1'b1, 9, -1);
    arr = '{5, -1, 1, -1}; glitch[2] = 1'b1; run_frame(1'b1, 1'b1, 10, -1);
    glitch[2] = 1'b0;
    arr = '{7, 8, -1, -1}; run_frame(1'b0, 1'b1, 12, -1);

    // Reset mid-frame with arrivals pending; release with tin=0 (idle).
    arr = '{0, 1, 5, 6};   run_frame(1'b1, 1'b1, 10, 3);
    tin = 1'b0; t_in = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    arr = '{2, 3, -1, 0};  run_frame(1'b1, 1'b1, 8, -1);
    ph = 1'b1;

    for (int n = 0; n < 150; n++) begin
      ph = ~ph;
      L = int'($urandom_range(2, 12));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) arr[c] = -1;
        else if (n % 3 == 0) arr[c] = int'($urandom_range(0, 3));
        else arr[c] = int'($urandom_range(0, 11));
        glitch[c] = ($urandom_range(0, 3) == 0);
      end
      if (n == 80) begin
        run_frame(ph, 1'b1, 8, 3);
        t_in = {CH{ph}};
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        run_frame(1'b1, (ph == 1'b0), L, -1);
        ph = 1'b1;
      end else begin
        run_frame(ph, 1'b1, L, -1);
      end
    end

    ph = ~ph;
    arr = '{-1, -1, -1, -1};
    run_frame(ph, 1'b1, 4, -1);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/te_wta.md
TE_WTA -- requirements
Module: te_wta

Interface
REQ-001 SHALL have parameter BITS, default 3, binary width of encoded values; frame window 2**BITS cycles.
REQ-002 SHALL have parameter CHANNELS, default 4, number of temporal inputs raced (minimum 2).
REQ-003 SHALL have parameter MODE, default 0: 0 = earliest arrival wins, 1 = latest arrival wins.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tin  input  1  frame phase; each toggle starts a new frame; 0 = rising-edge events, 1 = falling-edge (inverted) events.
REQ-007 SHALL have port t_in  input  CHANNELS  temporal-encoded lines, one per channel.
REQ-008 SHALL have port valid  output  1  one-cycle pulse, result of the just-closed frame.
REQ-009 SHALL have port win_idx  output  clog2(CHANNELS)  winning channel index.
REQ-010 SHALL have port win_time  output  BITS+1  winner's arrival count.
REQ-011 SHALL have port tie  output  1  more than one channel shares the winning time.
REQ-012 SHALL have port none  output  1  no channel arrived in the frame.
REQ-013 SHALL have port times  output  CHANNELS*(BITS+1)  per-channel arrival counts, channel 0 in LSBs.

Function
REQ-014 SHALL register tin into tin_q each cycle; boundary = (tin != tin_q).
REQ-015 SHALL use FSM states IDLE and RACE; IDLE->RACE on first boundary, no valid on that transition; RACE stays RACE.
REQ-016 SHALL, on a boundary in RACE: latch old-frame results to outputs, pulse valid next cycle, clear cnt, seen, recorded times to sentinel 2**BITS.
REQ-017 SHALL compute active = t_in XOR {CHANNELS{tin_q}}; arrival = active AND NOT seen.
REQ-018 SHALL, in non-boundary RACE cycles, record time=cnt and set seen for each arriving channel; first cycle after boundary is time 0.
REQ-019 SHALL increment cnt (BITS+1 wide) each non-boundary RACE cycle, saturating at 2**BITS.
REQ-020 SHALL ignore arrivals when cnt == 2**BITS (late) and arrivals sampled in the boundary cycle.
REQ-021 SHALL, MODE=0, select the minimum recorded time; MODE=1, the maximum among arrived channels.
REQ-022 SHALL break ties to the lowest index and assert tie.
REQ-023 SHALL, if no channel arrived, assert none with win_idx=0, win_time=2**BITS, tie=0.
REQ-024 SHALL hold win_idx, win_time, tie, none, times stable until the next valid.
REQ-025 SHALL treat a channel as arrived once per frame; later deassertion/glitches ignored.

Reset
REQ-026 SHALL, on rst, asynchronously clear all outputs, cnt, seen, tin_q to 0, times registers to sentinel, state to IDLE.
REQ-027 SHALL discard an in-progress frame on reset mid-frame; no valid for it.
REQ-028 SHALL, if tin=1 at reset release, see an immediate boundary and enter RACE without valid.

Configuration
REQ-029 SHALL support macro TE_WTA_TIMES_EN: defined -> times carries latched per-channel counts (sentinel 2**BITS for non-arrivals); undefined -> times driven constant 0, port still present, winner logic unchanged.

Verification
REQ-030 SHALL cover: BITS=3, CHANNELS=4, MODE=0, tin=0 frame, channels rise at cycles 5,2,7,3 -> valid after next toggle with win_idx=1, win_time=2, tie=0, none=0.
REQ-031 SHALL cover: tin=1 frame, channels fall at 4,4,6,never -> win_idx=0, win_time=4, tie=1; times (TIMES_EN) = 4,4,6,8.
REQ-032 SHALL cover: MODE=1, arrivals 1,6,3,never -> win_idx=1, win_time=6, tie=0.
REQ-033 SHALL cover: frame with no transitions -> none=1, win_time=8, win_idx=0.
REQ-034 SHALL cover: rst pulsed at frame cycle 3 with arrivals pending -> outputs 0, no valid until one full frame after first toggle post-reset.
REQ-035 SHALL cover: channel 2 glitches high at cycle 1 then low, channel 0 rises at cycle 5 -> win_idx=2, win_time=1.
